ascon_inv_linear_diffusion: RTL and testbench
=============================================

Name: ascon_inv_linear_diffusion

Overview:
- Iterative inverse of the ASCON linear diffusion layer over the five 64-bit state words.
- Recovers x0..x4 from t0..t4, where t = x ^ R(x,a) ^ R(x,b) per word.
- Used for decryption-side verification, key-recovery test benches and round-trip checks against Linear_Diffusion.
- Uses the identity (I+N)^-1 = prod_{k=0..5}(I + N^(2^k)). Each of 6 rounds applies y = y ^ R(y, a·2^k) ^ R(y, b·2^k) to all five words in parallel, with a valid/ready handshake on both sides.

Parameters:
- BITS, 64, word width. Only 64 is supported; elaboration error otherwise. Round count = log2(BITS) = 6.
- USE_ROTATE, 1, 1 = R is rotate-right (ASCON-correct); 0 = R is logical shift-right (inverse of the shift-based forward variant).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input words present
- in_ready  out  1  block can accept (IDLE only)
- t0,t1,t2,t3,t4  in  BITS each  diffused words to invert
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- x0,x1,x2,x3,x4  out  BITS each  recovered words
- busy  out  1  high in RUN or DONE

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset (async, any state, including mid-RUN): state=IDLE, round counter=0, x0..x4=0, out_valid=0. In-flight data is discarded. in_ready=1 once in IDLE.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready at an edge: load t0..t4 into working regs, round counter=0, go to RUN.
- RUN:
  - in_ready=0; in_valid is ignored.
  - Each edge applies round k = counter to all five words and increments the counter.
  - After the edge with k=5, go to DONE.
  - Exactly 6 RUN cycles.
- Round k, word i, constants (a_i, b_i):
  - Rotate mode: amounts are (a_i·2^k) mod 64 and (b_i·2^k) mod 64.
  - Shift mode: amounts are a_i·2^k and b_i·2^k; any amount >=64 contributes 0.
  - All arithmetic is pure XOR. There is no carry or width growth.
- DONE:
  - out_valid=1; x0..x4 hold the working regs and stay stable while out_ready=0.
  - On out_valid&&out_ready: go to IDLE and clear out_valid. x0..x4 retain their last values.
- Latency: accept edge, then 6 round edges; out_valid rises after the 6th round edge, i.e. 7 edges after accept. Minimum spacing between accepts is 8 cycles.
- Inputs are sampled only at the accept edge. Later changes on t* have no effect.
- in_ready is combinational from state only (no combinational in_valid→in_ready path). out_valid is registered.
- Result must equal the exact inverse: forward(ascon_inv(t)) == t for all t, in both modes.

Decomposition:
- Package ascon_pkg holds:
  - BITS_DEFAULT=64, N_ROUNDS_INV=6.
  - Typedef word_t (logic [63:0]) and state_t (word_t [4:0]).
  - Per-word constant arrays LD_A = {19,61,1,10,7} and LD_B = {28,39,6,17,41}.
  - FSM enum inv_ld_state_e {IDLE, RUN, DONE}.
- Linear_Diffusion is switched to the same package constants, so forward and inverse cannot diverge.
- One sub-module, ascon_inv_ld_round: combinational single round for one word. Inputs are word, a, b, k and USE_ROTATE; it is instantiated 5 times.

Test Plan:
- Zero input: t*=0, USE_ROTATE=1 → after 7 edges out_valid=1, x*=0. in_ready=0 throughout RUN/DONE.
- All-ones invariance: t*=64'hFFFF_FFFF_FFFF_FFFF, rotate mode → x*=64'hFFFF_FFFF_FFFF_FFFF. Shift mode, t*=64'h1 → x*=64'h1.
- Round trip: 1000 random x, forward-model t=L(x) in each mode → ascon_inv returns x bit-exact. Also run Linear_Diffusion→ascon_inv chained in shift mode with 64'h0123_4567_89AB_CDEF on all words.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid → x* stable, no new accept despite in_valid=1. Raise out_ready → IDLE next edge, next accept 1 cycle later.
- Input churn: change t* every cycle during RUN → result matches the value sampled at accept.
- Reset mid-RUN: assert rst asynchronously at round 3 → x*=0, out_valid=0 immediately. After release, a fresh accept completes correctly in 7 edges.

Source files
------------

// File: rtl/ascon_pkg.sv
// ascon_pkg
// Shared definitions for the ASCON linear diffusion layer and its inverse.
// Holds the word/state types, the per-word rotation constants used by both
// the forward and inverse layers (so the two cannot drift apart), the
// inverse round count and the inverse FSM state encoding.
package ascon_pkg;

  localparam int BITS_DEFAULT = 64;
  // (I+N)^-1 = prod_{k=0..5} (I + N^(2^k)) because N^64 = 0 for a 64-bit word.
  localparam int N_ROUNDS_INV = 6;

  typedef logic [63:0] word_t;
  typedef word_t [4:0] state_t;

  // Index i holds the (a, b) rotation pair for state word x_i.
  localparam logic [5:0] LD_A [5] = '{6'd19, 6'd61, 6'd1, 6'd10, 6'd7};
  localparam logic [5:0] LD_B [5] = '{6'd28, 6'd39, 6'd6, 6'd17, 6'd41};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } inv_ld_state_e;

endpackage

// File: rtl/ascon_inv_linear_diffusion_round.sv
// ascon_inv_ld_round
// Combinational single inverse-diffusion round for one 64-bit word:
//   word_o = word_i ^ R(word_i, a*2^k) ^ R(word_i, b*2^k)
// Ports:
//   word_i  in   64  working word before this round
//   a, b    in   6   base rotation/shift constants for this word
//   k       in   3   round index (0..5), scales the amounts by 2^k
//   word_o  out  64  working word after this round
// USE_ROTATE selects rotate-right (1) or logical shift-right (0) for R.
module ascon_inv_ld_round
  import ascon_pkg::*;
#(
  parameter bit USE_ROTATE = 1'b1
) (
  input  word_t       word_i,
  input  logic [5:0]  a,
  input  logic [5:0]  b,
  input  logic [2:0]  k,
  output word_t       word_o
);

  // Scaled amounts can reach 61*32, so keep enough width to tell when a
  // shift amount has run off the end of the word.
  logic [10:0] amt_a;
  logic [10:0] amt_b;

  assign amt_a = {5'd0, a} << k;
  assign amt_b = {5'd0, b} << k;

  // Rotation only needs the amount mod 64; shifting by 64 or more leaves
  // nothing, so that term drops out of the XOR.
  function automatic word_t r_op(input word_t w, input logic [10:0] amt);
    logic [127:0] dbl;
    word_t        res;
    if (USE_ROTATE) begin
      dbl = {w, w} >> amt[5:0];
      res = dbl[63:0];
    end else if (amt >= 11'd64) begin
      res = '0;
    end else begin
      res = w >> amt[5:0];
    end
    return res;
  endfunction

  assign word_o = word_i ^ r_op(word_i, amt_a) ^ r_op(word_i, amt_b);

endmodule

// File: rtl/ascon_inv_linear_diffusion.sv
// ascon_inv_linear_diffusion
// Iterative inverse of the ASCON linear diffusion layer. Loads t0..t4 on an
// accepted handshake, runs 6 rounds (one per clock) on all five words in
// parallel, then presents x0..x4 until the consumer takes them.
// Ports:
//   clk, rst              clock (rising edge), async active-high reset
//   in_valid / in_ready   input handshake; in_ready only in IDLE
//   t0..t4                diffused words, sampled only on the accept edge
//   out_valid / out_ready output handshake; out_valid registered, DONE only
//   x0..x4                recovered words, held after the output handshake
//   busy                  high while in RUN or DONE
module ascon_inv_linear_diffusion
  import ascon_pkg::*;
#(
  parameter int BITS       = BITS_DEFAULT,
  parameter bit USE_ROTATE = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] t0,
  input  logic [BITS-1:0] t1,
  input  logic [BITS-1:0] t2,
  input  logic [BITS-1:0] t3,
  input  logic [BITS-1:0] t4,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] x0,
  output logic [BITS-1:0] x1,
  output logic [BITS-1:0] x2,
  output logic [BITS-1:0] x3,
  output logic [BITS-1:0] x4,
  output logic            busy
);

  // The round count and constants are tied to a 64-bit word.
  if (BITS != 64) begin : g_bits_check
    $error("ascon_inv_linear_diffusion: only BITS == 64 is supported");
  end

  inv_ld_state_e state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  state_t        work_q, work_d;
  logic          out_valid_q, out_valid_d;
  word_t         round_out [5];

  for (genvar i = 0; i < 5; i++) begin : g_round
    ascon_inv_ld_round #(
      .USE_ROTATE(USE_ROTATE)
    ) u_round (
      .word_i(work_q[i]),
      .a     (LD_A[i]),
      .b     (LD_B[i]),
      .k     (cnt_q),
      .word_o(round_out[i])
    );
  end

  // Next-state logic: IDLE accepts, RUN applies round cnt_q, DONE waits for
  // the consumer. in_valid is only looked at in IDLE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    work_d      = work_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d[0] = t0;
          work_d[1] = t1;
          work_d[2] = t2;
          work_d[3] = t3;
          work_d[4] = t4;
          cnt_d     = 3'd0;
          state_d   = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < 5; i++) begin
          work_d[i] = round_out[i];
        end
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'(N_ROUNDS_INV - 1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      work_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign x0        = work_q[0];
  assign x1        = work_q[1];
  assign x2        = work_q[2];
  assign x3        = work_q[3];
  assign x4        = work_q[4];

endmodule

// File: tb/tb_ascon_inv_linear_diffusion.sv
// tb_ascon_inv_linear_diffusion
// Drives a rotate-mode and a shift-mode instance side by side with directed
// vectors and forward-model round trips, checking results, latency and the
// handshake behaviour.
module tb_ascon_inv_linear_diffusion;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic [319:0] tRot;
  logic [319:0] tShf;
  logic [319:0] xRot;
  logic [319:0] xShf;
  logic         rdyR, rdyS, vldR, vldS, busyR, busyS;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  ascon_inv_linear_diffusion #(.BITS(64), .USE_ROTATE(1'b1)) dut_rot (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdyR),
    .t0(tRot[63:0]), .t1(tRot[127:64]), .t2(tRot[191:128]),
    .t3(tRot[255:192]), .t4(tRot[319:256]),
    .out_valid(vldR), .out_ready(out_ready),
    .x0(xRot[63:0]), .x1(xRot[127:64]), .x2(xRot[191:128]),
    .x3(xRot[255:192]), .x4(xRot[319:256]),
    .busy(busyR)
  );

  ascon_inv_linear_diffusion #(.BITS(64), .USE_ROTATE(1'b0)) dut_shf (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdyS),
    .t0(tShf[63:0]), .t1(tShf[127:64]), .t2(tShf[191:128]),
    .t3(tShf[255:192]), .t4(tShf[319:256]),
    .out_valid(vldS), .out_ready(out_ready),
    .x0(xShf[63:0]), .x1(xShf[127:64]), .x2(xShf[191:128]),
    .x3(xShf[255:192]), .x4(xShf[319:256]),
    .busy(busyS)
  );

  // Forward diffusion layer, written directly from t = x ^ R(x,a) ^ R(x,b).
  function automatic logic [63:0] rFwd(input logic [63:0] w, input int n, input bit rot);
    if (rot) return (w >> n) | (w << (64 - n));
    return w >> n;
  endfunction

  function automatic logic [319:0] fwd(input logic [319:0] x, input bit rot);
    int aa [5] = '{19, 61, 1, 10, 7};
    int bb [5] = '{28, 39, 6, 17, 41};
    logic [319:0] t;
    logic [63:0]  w;
    for (int i = 0; i < 5; i++) begin
      w = x[64*i +: 64];
      t[64*i +: 64] = w ^ rFwd(w, aa[i], rot) ^ rFwd(w, bb[i], rot);
    end
    return t;
  endfunction

  function automatic logic [319:0] rand320();
    return {$urandom, $urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic checkOutput(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Presents one input set for a single clock; returns at the negedge after
  // the accept edge.
  task automatic applyStimulus(input logic [319:0] tr, input logic [319:0] ts);
    @(negedge clk);
    tRot     = tr;
    tShf     = ts;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts round edges until both results are valid, optionally scrambling
  // the inputs every cycle; also checks that in_ready stays low meanwhile.
  task automatic waitDone(input string tag, input bit churn);
    int n = 0;
    bit sawReady = (rdyR || rdyS);
    while (!(vldR && vldS) && n < 20) begin
      if (churn) begin
        tRot = rand320();
        tShf = rand320();
      end
      @(negedge clk);
      n++;
      if (rdyR || rdyS) sawReady = 1'b1;
    end
    checkOutput({tag, "_latency"}, 320'(n), 320'd6);
    checkOutput({tag, "_in_ready_low"}, 320'(sawReady), 320'd0);
  endtask

  task automatic releaseOut(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, "_idle"}, 320'({vldR, vldS, rdyR, rdyS, busyR, busyS}), 320'b001100);
  endtask

  task automatic runTxn(input string tag, input logic [319:0] tr, input logic [319:0] ts,
                        input logic [319:0] er, input logic [319:0] es);
    applyStimulus(tr, ts);
    waitDone(tag, 1'b0);
    checkOutput({tag, "_rot"}, xRot, er);
    checkOutput({tag, "_shf"}, xShf, es);
    releaseOut(tag);
  endtask

  logic [319:0] xs, xa, xb, xc;
  logic [319:0] handRot;
  bit           held;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; tRot = '0; tShf = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_flags", 320'({vldR, vldS, rdyR, rdyS, busyR, busyS}), 320'b001100);
    checkOutput("reset_x", {xRot ^ xShf} | xRot, 320'd0);

    // Directed vectors.
    runTxn("zero", '0, '0, '0, '0);
    runTxn("ones", {5{64'hFFFF_FFFF_FFFF_FFFF}}, {5{64'h1}},
           {5{64'hFFFF_FFFF_FFFF_FFFF}}, {5{64'h1}});
    handRot = {64'h0200_0000_0080_0001, 64'h0040_8000_0000_0001, 64'h8400_0000_0000_0001,
               64'h0000_0000_0200_0009, 64'h0000_2010_0000_0001};
    runTxn("hand", handRot, {256'd0, 64'h8000_1008_0000_0000},
           {5{64'h1}}, {256'd0, 64'h8000_0000_0000_0000});
    xs = {5{64'h0123_4567_89AB_CDEF}};
    runTxn("chain", fwd(xs, 1'b1), fwd(xs, 1'b0), xs, xs);

    // Random round trips through the forward model.
    for (int i = 0; i < 1000; i++) begin
      xa = rand320();
      xb = rand320();
      applyStimulus(fwd(xa, 1'b1), fwd(xb, 1'b0));
      waitDone("rand", 1'b0);
      checkOutput("rand_rot", xRot, xa);
      checkOutput("rand_shf", xShf, xb);
      @(negedge clk); out_ready = 1'b1;
      @(negedge clk); out_ready = 1'b0;
    end

    // Backpressure: results hold and nothing new is taken while out_ready=0.
    xa = rand320();
    xb = rand320();
    applyStimulus(fwd(xa, 1'b1), fwd(xa, 1'b0));
    waitDone("bp", 1'b0);
    tRot = fwd(xb, 1'b1);
    tShf = fwd(xb, 1'b0);
    in_valid = 1'b1;
    held = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (xRot !== xa || xShf !== xa || !vldR || !vldS || rdyR || rdyS) held = 1'b0;
    end
    checkOutput("bp_stable", 320'(held), 320'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("bp_release", 320'({vldR, vldS, rdyR, rdyS}), 320'b0011);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("bp_reaccept", 320'({busyR, busyS, rdyR, rdyS}), 320'b1100);
    waitDone("bp2", 1'b0);
    checkOutput("bp2_rot", xRot, xb);
    checkOutput("bp2_shf", xShf, xb);
    releaseOut("bp2");

    // Input churn during RUN must not disturb the sampled values.
    xc = rand320();
    applyStimulus(fwd(xc, 1'b1), fwd(xc, 1'b0));
    waitDone("churn", 1'b1);
    checkOutput("churn_rot", xRot, xc);
    checkOutput("churn_shf", xShf, xc);
    releaseOut("churn");

    // Asynchronous reset while round 3 is pending.
    applyStimulus(fwd(xa, 1'b1), fwd(xa, 1'b0));
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_mid_x", xRot | xShf, 320'd0);
    checkOutput("rst_mid_flags", 320'({vldR, vldS, rdyR, rdyS}), 320'b0011);
    @(negedge clk);
    rst = 1'b0;
    runTxn("post_rst", fwd(xc, 1'b1), fwd(xb, 1'b0), xc, xb);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
